core_sequencer: RTL and testbench



---
 rtl/core_sequencer.sv | 166 ++++++++++++++++
 tb/tb_core_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// ----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle instruction sequencer. It walks each instruction through
// FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK and then back to FETCH. An
// exception raised in EXECUTE, or a misaligned taken branch at WRITEBACK,
// goes through a one-cycle TRAP phase. That phase saves the faulting pc in
// epc and redirects to TRAP_VECTOR.
//
// Parameters
//   XLEN          width of pc, branch_target and epc
//   RESET_VECTOR  pc after reset (word-aligned)
//   TRAP_VECTOR   pc loaded on trap (word-aligned)
//
// Ports
//   CLK100MHZ      in   system clock, rising-edge active
//   rst_n          in   asynchronous active-low reset
//   run            in   fetch enable; low parks the sequencer in FETCH
//   imem_ready     in   instruction word valid this cycle
//   ex_stall       in   multi-cycle execute in progress
//   trap_req       in   current instruction raises an exception (EXECUTE)
//   mem_access     in   current instruction is a load/store
//   dmem_ready     in   data access completes this cycle
//   taken_branch   in   redirect pc at writeback
//   branch_target  in   redirect address
//   phase          out  FETCH=0 DECODE=1 EXECUTE=2 MEM=3 WRITEBACK=4 TRAP=5
//   pc             out  address of the current instruction
//   fetch_req      out  instruction fetch request (combinational)
//   mem_req        out  data access request (combinational)
//   rf_we          out  register-file write strobe (combinational)
//   trap_taken     out  one-cycle trap pulse (combinational)
//   halted         out  parked in FETCH because run was low (registered)
//   epc            out  pc of the trapping instruction
//   instret        out  retired instruction count (wraps)
//   cycle          out  cycles since reset (wraps)
// ----------------------------------------------------------------------------
module core_sequencer #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'('h100)
) (
   input  logic            CLK100MHZ,
   input  logic            rst_n,
   input  logic            run,
   input  logic            imem_ready,
   input  logic            ex_stall,
   input  logic            trap_req,
   input  logic            mem_access,
   input  logic            dmem_ready,
   input  logic            taken_branch,
   input  logic [XLEN-1:0] branch_target,
   output logic [2:0]      phase,
   output logic [XLEN-1:0] pc,
   output logic            fetch_req,
   output logic            mem_req,
   output logic            rf_we,
   output logic            trap_taken,
   output logic            halted,
   output logic [XLEN-1:0] epc,
   output logic [63:0]     instret,
   output logic [63:0]     cycle
);

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      TRAP      = 3'd5
   } state_t;

   state_t state;
   state_t state_next;
   logic   br_misaligned;
   logic   retire;

   // A taken branch to a non-word address cannot retire; it faults instead.
   assign br_misaligned = taken_branch && (branch_target[1:0] != 2'b00);

   assign phase = state;

   // ---- state register ----
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // ---- next-state and strobe decode ----
   always_comb begin
      state_next = state;
      fetch_req  = 1'b0;
      mem_req    = 1'b0;
      rf_we      = 1'b0;
      trap_taken = 1'b0;
      retire     = 1'b0;
      case (state)
         FETCH: begin
            // State is already FETCH during reset, so gating with rst_n is
            // enough to keep every strobe low while reset is held.
            fetch_req = run && rst_n;
            if (run && imem_ready) begin
               state_next = DECODE;
            end
         end
         DECODE: begin
            state_next = EXECUTE;
         end
         EXECUTE: begin
            // A stall wins over a pending trap; the trap is taken once the
            // multi-cycle operation completes.
            if (!ex_stall) begin
               state_next = trap_req ? TRAP : MEM;
            end
         end
         MEM: begin
            mem_req = mem_access;
            if (!(mem_access && !dmem_ready)) begin
               state_next = WRITEBACK;
            end
         end
         WRITEBACK: begin
            if (br_misaligned) begin
               state_next = TRAP;
            end else begin
               rf_we      = 1'b1;
               retire     = 1'b1;
               state_next = FETCH;
            end
         end
         TRAP: begin
            trap_taken = 1'b1;
            state_next = FETCH;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // ---- architectural registers and counters ----
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         pc      <= RESET_VECTOR;
         epc     <= '0;
         instret <= '0;
         cycle   <= '0;
         halted  <= 1'b0;
      end else begin
         cycle  <= cycle + 64'd1;
         halted <= (state == FETCH) && !run;
         if (retire) begin
            pc      <= taken_branch ? branch_target : pc + XLEN'(4);
            instret <= instret + 64'd1;
         end
         if (state == TRAP) begin
            epc <= pc;
            pc  <= TRAP_VECTOR;
         end
      end
   end

endmodule

// File: tb/tb_core_sequencer.sv
// ----------------------------------------------------------------------------
// tb_core_sequencer
//
// Directed bench for core_sequencer. Stimulus pushes each expected retire or
// trap event into a queue. A negedge monitor pops an entry whenever rf_we or
// trap_taken is seen and compares the event kind and pc. Architectural state
// (pc, epc, instret, cycle, phase) is checked directly against hand-computed
// constants at fixed cycle offsets.
// ----------------------------------------------------------------------------
module tb_core_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run;
   logic        imem_ready;
   logic        ex_stall;
   logic        trap_req;
   logic        mem_access;
   logic        dmem_ready;
   logic        taken_branch;
   logic [31:0] branch_target;
   logic [2:0]  phase;
   logic [31:0] pc;
   logic        fetch_req;
   logic        mem_req;
   logic        rf_we;
   logic        trap_taken;
   logic        halted;
   logic [31:0] epc;
   logic [63:0] instret;
   logic [63:0] cycle;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          is_trap;
      logic [31:0] pc;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;

   core_sequencer #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0),
      .TRAP_VECTOR  (32'h100)
   ) dut (
      .CLK100MHZ     (clk),
      .rst_n         (rst_n),
      .run           (run),
      .imem_ready    (imem_ready),
      .ex_stall      (ex_stall),
      .trap_req      (trap_req),
      .mem_access    (mem_access),
      .dmem_ready    (dmem_ready),
      .taken_branch  (taken_branch),
      .branch_target (branch_target),
      .phase         (phase),
      .pc            (pc),
      .fetch_req     (fetch_req),
      .mem_req       (mem_req),
      .rf_we         (rf_we),
      .trap_taken    (trap_taken),
      .halted        (halted),
      .epc           (epc),
      .instret       (instret),
      .cycle         (cycle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_ev(input bit is_trap, input logic [31:0] at_pc);
      ev_t e;
      e.is_trap = is_trap;
      e.pc      = at_pc;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: any retire or trap strobe must match the next
   // expected event.
   always @(negedge clk) begin
      if (rst_n && (rf_we || trap_taken)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event rf_we=%0b trap_taken=%0b pc=%0h expected=none",
                     rf_we, trap_taken, pc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("ev_is_trap", {63'b0, trap_taken}, {63'b0, mon_e.is_trap});
            chk("ev_rf_we",   {63'b0, rf_we},      {63'b0, !mon_e.is_trap});
            chk("ev_pc",      {32'b0, pc},         {32'b0, mon_e.pc});
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      run           = 1'b1;
      imem_ready    = 1'b1;
      ex_stall      = 1'b0;
      trap_req      = 1'b0;
      mem_access    = 1'b0;
      dmem_ready    = 1'b1;
      taken_branch  = 1'b0;
      branch_target = 32'h0;

      // Reset state
      #2;
      chk("rst_phase",     {61'b0, phase}, 64'd0);
      chk("rst_pc",        {32'b0, pc},    64'd0);
      chk("rst_epc",       {32'b0, epc},   64'd0);
      chk("rst_instret",   instret,        64'd0);
      chk("rst_cycle",     cycle,          64'd0);
      chk("rst_fetch_req", {63'b0, fetch_req}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Three straight-line instructions, 5 cycles each
      push_ev(1'b0, 32'h0);
      push_ev(1'b0, 32'h4);
      push_ev(1'b0, 32'h8);
      step(5);
      chk("seq_pc_1", {32'b0, pc}, 64'h4);
      step(5);
      chk("seq_pc_2", {32'b0, pc}, 64'h8);
      step(5);
      chk("seq_pc_3",      {32'b0, pc},    64'hc);
      chk("seq_instret",   instret,        64'd3);
      chk("seq_cycle",     cycle,          64'd15);
      chk("seq_phase",     {61'b0, phase}, 64'd0);

      // Park in FETCH with run low
      run = 1'b0;
      step(3);
      chk("halt_halted",    {63'b0, halted},    64'd1);
      chk("halt_fetch_req", {63'b0, fetch_req}, 64'd0);
      chk("halt_phase",     {61'b0, phase},     64'd0);
      chk("halt_pc",        {32'b0, pc},        64'hc);
      chk("halt_cycle",     cycle,              64'd18);

      // Resume at the same pc; EXECUTE stalls 4 cycles, then traps
      run      = 1'b1;
      ex_stall = 1'b1;
      trap_req = 1'b1;
      #1;
      chk("resume_fetch_req", {63'b0, fetch_req}, 64'd1);
      chk("resume_pc",        {32'b0, pc},        64'hc);
      step(1);
      run = 1'b0;
      chk("resume_halted", {63'b0, halted}, 64'd0);
      step(1);
      chk("stall_enter_ex", {61'b0, phase}, 64'd2);
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("stall_hold_ex", {61'b0, phase}, 64'd2);
      end
      ex_stall = 1'b0;
      push_ev(1'b1, 32'hc);
      step(1);
      chk("trap_phase", {61'b0, phase}, 64'd5);
      step(1);
      chk("trap_pc",      {32'b0, pc},    64'h100);
      chk("trap_epc",     {32'b0, epc},   64'hc);
      chk("trap_instret", instret,        64'd3);
      chk("trap_phase_f", {61'b0, phase}, 64'd0);
      chk("trap_cycle",   cycle,          64'd26);

      // Data access with dmem_ready low for 3 cycles
      trap_req   = 1'b0;
      mem_access = 1'b1;
      dmem_ready = 1'b0;
      run        = 1'b1;
      step(1);
      run = 1'b0;
      step(2);
      chk("mem_phase", {61'b0, phase}, 64'd3);
      chk("mem_req_0", {63'b0, mem_req}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("mem_req_hold", {63'b0, mem_req}, 64'd1);
      end
      dmem_ready = 1'b1;
      push_ev(1'b0, 32'h100);
      step(1);
      chk("mem_wb_phase", {61'b0, phase}, 64'd4);
      chk("mem_wb_req",   {63'b0, mem_req}, 64'd0);
      step(1);
      chk("mem_pc",      {32'b0, pc},    64'h104);
      chk("mem_instret", instret,        64'd4);
      chk("mem_cycle",   cycle,          64'd34);

      // Aligned taken branch
      mem_access    = 1'b0;
      taken_branch  = 1'b1;
      branch_target = 32'h40;
      push_ev(1'b0, 32'h104);
      run = 1'b1;
      step(1);
      run = 1'b0;
      step(3);
      chk("br_rf_we", {63'b0, rf_we}, 64'd1);
      step(1);
      chk("br_pc",      {32'b0, pc}, 64'h40);
      chk("br_instret", instret,     64'd5);

      // Misaligned taken branch faults at writeback
      branch_target = 32'h42;
      push_ev(1'b1, 32'h40);
      run = 1'b1;
      step(1);
      run = 1'b0;
      step(3);
      chk("mis_wb_phase", {61'b0, phase}, 64'd4);
      chk("mis_rf_we",    {63'b0, rf_we}, 64'd0);
      step(1);
      chk("mis_trap_phase", {61'b0, phase}, 64'd5);
      chk("mis_trap_pc",    {32'b0, pc},    64'h40);
      step(1);
      chk("mis_pc",      {32'b0, pc},  64'h100);
      chk("mis_epc",     {32'b0, epc}, 64'h40);
      chk("mis_instret", instret,      64'd5);
      chk("mis_cycle",   cycle,        64'd45);

      // Reset asserted mid-cycle while waiting in MEM
      taken_branch  = 1'b0;
      branch_target = 32'h0;
      mem_access    = 1'b1;
      dmem_ready    = 1'b0;
      run           = 1'b1;
      step(3);
      chk("rmem_phase", {61'b0, phase}, 64'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmem_phase_rst", {61'b0, phase},      64'd0);
      chk("rmem_pc",        {32'b0, pc},         64'd0);
      chk("rmem_epc",       {32'b0, epc},        64'd0);
      chk("rmem_instret",   instret,             64'd0);
      chk("rmem_cycle",     cycle,               64'd0);
      chk("rmem_mem_req",   {63'b0, mem_req},    64'd0);
      chk("rmem_fetch_req", {63'b0, fetch_req},  64'd0);
      chk("rmem_rf_we",     {63'b0, rf_we},      64'd0);
      chk("rmem_trap",      {63'b0, trap_taken}, 64'd0);
      mem_access = 1'b0;
      dmem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      push_ev(1'b0, 32'h0);
      step(1);
      chk("post_rst_phase", {61'b0, phase}, 64'd1);
      chk("post_rst_pc",    {32'b0, pc},    64'd0);
      step(4);
      chk("post_rst_pc2",     {32'b0, pc}, 64'h4);
      chk("post_rst_instret", instret,     64'd1);
      chk("post_rst_cycle",   cycle,       64'd5);
      run = 1'b0;
      step(2);

      chk("events_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
